// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter with a programmable bit period.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [DIV_W-1:0]         cfg_div,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    output logic                     uart_tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [7:0]        shift;
    logic [2:0]        bit_cnt;
    logic [DIV_W-1:0]  div_q, clk_cnt;
    logic              push, pop, bit_end;
    logic [LW-1:0]     level_next;

    assign push       = wr_valid && wr_ready;
    assign bit_end    = clk_cnt == div_q - DIV_W'(1);
    assign pop        = (fifo_level != '0) && (state == IDLE || (state == STOP && bit_end));
    assign level_next = fifo_level + LW'(push) - LW'(pop);
    assign busy       = (state != IDLE) || (fifo_level != '0);

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_data;

    // wr_ready is registered from the next level so it never depends on wr_valid combinationally
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            wr_ready   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= level_next;
            wr_ready   <= level_next != LW'(DEPTH);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            uart_tx <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
            clk_cnt <= '0;
            div_q   <= DIV_W'(2);
        end else if (pop) begin
            state   <= START;
            shift   <= mem[rd_ptr];
            uart_tx <= 1'b0;
            bit_cnt <= '0;
            clk_cnt <= '0;
            div_q   <= (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
        end else begin
            clk_cnt <= (state == IDLE || bit_end) ? '0 : clk_cnt + DIV_W'(1);
            case (state)
                IDLE: uart_tx <= 1'b1;
                START:
                    if (bit_end) begin
                        state   <= DATA;
                        uart_tx <= shift[0];
                        shift   <= shift >> 1;
                    end
                DATA:
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            uart_tx <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                STOP:
                    if (bit_end) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus with a scoreboard of written bytes checked by a serial-line decoder.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] cfg_div;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        uart_tx;
    logic        busy;
    logic [3:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];
    int         mon_div = 4;
    int         frames_started = 0;
    int         frames_done = 0;
    int         m_gap = 0;
    int         m_gap_last = 0;
    bit         m_act = 0;
    int         m_cyc;
    bit         m_bad, m_unexp;
    logic [7:0] m_exp, m_dec;
    logic [9:0] m_frame;

    uart_tx_fifo #(.DEPTH(8), .DIV_W(16)) dut (
        .clk(clk), .resetn(resetn), .cfg_div(cfg_div), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_ready(wr_ready), .uart_tx(uart_tx), .busy(busy),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Line decoder: every cycle of a frame must match the expected bit, so bit length is checked exactly
    always @(negedge clk) begin
        if (!resetn) begin
            m_act = 0;
            m_gap = 0;
        end else begin
            if (!m_act) begin
                if (uart_tx === 1'b0) begin
                    m_act = 1;
                    m_cyc = 0;
                    m_bad = 0;
                    m_dec = '0;
                    m_gap_last = m_gap;
                    frames_started++;
                    m_unexp = (sb.size() == 0);
                    m_exp = m_unexp ? 8'h00 : sb.pop_front();
                    m_frame = {1'b1, m_exp, 1'b0};
                end else m_gap++;
            end
            if (m_act) begin
                if (uart_tx !== m_frame[m_cyc / mon_div]) m_bad = 1;
                if (m_cyc % mon_div == mon_div / 2 && m_cyc / mon_div >= 1 && m_cyc / mon_div <= 8)
                    m_dec[m_cyc / mon_div - 1] = uart_tx;
                if (m_cyc == 10 * mon_div - 1) begin
                    checks++;
                    assert (m_unexp == 0 && m_dec === m_exp) else begin
                        errors++;
                        $error("FAIL frame_data: got %02h (unexpected=%0d) expected %02h", m_dec, m_unexp, m_exp);
                    end
                    checks++;
                    assert (m_bad == 0) else begin
                        errors++;
                        $error("FAIL frame_timing: got bad=%0d expected 0 for byte %02h", m_bad, m_exp);
                    end
                    m_act = 0;
                    m_gap = 0;
                    frames_done++;
                end
                m_cyc++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with wr_valid still high
    task automatic send(input logic [7:0] b);
        int t = 0;
        wr_valid = 1'b1;
        wr_data  = b;
        while (wr_ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("send_timeout", 32'(t < 5000), 1);
        sb.push_back(b);
        @(negedge clk);
    endtask

    task automatic wait_frames(input int target);
        int t = 0;
        while (frames_done < target && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_timeout", 32'(frames_done >= target), 1);
    endtask

    initial begin
        int lows;
        int fs;
        resetn   = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        cfg_div  = 16'd4;
        repeat (3) @(negedge clk);
        chk("rst_tx", uart_tx, 1);
        chk("rst_ready", wr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        resetn = 1'b1;
        chk("rel_ready_before_edge", wr_ready, 0);
        @(negedge clk);
        chk("rel_ready_first_edge", wr_ready, 1);

        // single byte 0xA5, div 4
        mon_div = 4;
        send(8'hA5);
        wr_valid = 1'b0;
        chk("a5_tx_at_e0", uart_tx, 1);
        chk("a5_level_at_e0", fifo_level, 1);
        chk("a5_busy_at_e0", busy, 1);
        @(negedge clk);
        chk("a5_tx_at_e1", uart_tx, 0);
        chk("a5_level_at_e1", fifo_level, 0);
        wait_frames(1);
        @(negedge clk);
        chk("a5_busy_after", busy, 0);
        chk("a5_tx_after", uart_tx, 1);

        // back-to-back 0x55, 0x0F
        send(8'h55);
        send(8'h0F);
        wr_valid = 1'b0;
        wait_frames(3);
        chk("b2b_gap", m_gap_last, 0);

        // full FIFO, div 16
        cfg_div = 16'd16;
        mon_div = 16;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 9; i++) send(8'(i));
        chk("full_level", fifo_level, 8);
        chk("full_ready", wr_ready, 0);
        @(negedge clk);
        chk("full_ready_hold", wr_ready, 0);
        send(8'h09);
        wr_valid = 1'b0;
        chk("full_level_after_b9", fifo_level, 8);
        wait_frames(13);
        chk("full_sb_empty", sb.size(), 0);

        // simultaneous push and pop at level 3, div 4
        cfg_div = 16'd4;
        mon_div = 4;
        repeat (5) @(negedge clk);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        wr_valid = 1'b0;
        repeat (37) @(negedge clk);
        chk("pp_level_before", fifo_level, 3);
        send(8'h66);
        wr_valid = 1'b0;
        chk("pp_level_after", fifo_level, 3);
        wait_frames(18);
        chk("pp_sb_empty", sb.size(), 0);

        // minimum divider
        cfg_div = 16'd0;
        mon_div = 2;
        repeat (5) @(negedge clk);
        send(8'hFF);
        wr_valid = 1'b0;
        wait_frames(19);
        @(negedge clk);
        chk("min_busy_after", busy, 0);

        // reset during data bit 3 of 0x3C with two bytes queued
        cfg_div = 16'd4;
        mon_div = 4;
        repeat (5) @(negedge clk);
        send(8'h3C);
        send(8'h81);
        send(8'h7E);
        wr_valid = 1'b0;
        repeat (16) @(negedge clk);
        chk("mid_level_before", fifo_level, 2);
        resetn = 1'b0;
        #1;
        chk("mid_rst_tx", uart_tx, 1);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", wr_ready, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        fs = frames_started;
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("mid_no_low", lows, 0);
        chk("mid_no_frames", frames_started, fs);
        chk("mid_level_after", fifo_level, 0);
        chk("mid_busy_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of cfg_div.
REQ-003 SHALL have port clk, input, 1, the single clock for all state.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cfg_div, input, DIV_W, clocks per UART bit.
REQ-006 SHALL have port wr_valid, input, 1, a byte is offered on wr_data.
REQ-007 SHALL have port wr_data, input, 8, the byte to transmit.
REQ-008 SHALL have port wr_ready, output, 1, the FIFO can accept a byte.
REQ-009 SHALL have port uart_tx, output, 1, serial line, idle high.
REQ-010 SHALL have port busy, output, 1, a frame is in progress or the FIFO is non-empty.
REQ-011 SHALL have port fifo_level, output, $clog2(DEPTH)+1, count of stored entries.

Function
REQ-012 SHALL accept a byte on a rising clk edge only when wr_valid and wr_ready are both 1.
REQ-013 SHALL drive wr_ready = (fifo_level != DEPTH) from registers only, with no combinational path from wr_valid.
REQ-014 SHALL keep wr_ready low when the FIFO is full, even in a cycle where a pop occurs.
REQ-015 SHALL send 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-016 SHALL use FSM states IDLE, START, DATA, STOP.
- IDLE -> START when FIFO non-empty: pop the head and load the shift register on the same edge.
- START -> DATA after one bit period.
- DATA -> STOP after 8 bit periods.
- STOP -> START if FIFO non-empty, else STOP -> IDLE.
REQ-017 SHALL hold each bit for exactly max(cfg_div, 2) clk cycles; cfg_div values 0 and 1 act as 2.
REQ-018 SHALL sample cfg_div once at frame start (entry to START); changes mid-frame take effect on the next frame only.
REQ-019 SHALL latency: a byte written at edge E0 into an empty FIFO with the FSM in IDLE drives uart_tx low from edge E0+1.
REQ-020 SHALL send back-to-back frames with no idle cycle: the next start bit begins on the cycle after the last stop-bit cycle.
REQ-021 SHALL register uart_tx so it is glitch-free, and hold it at 1 in IDLE.
REQ-022 SHALL, for a simultaneous push and pop, leave fifo_level unchanged and keep data order.
REQ-023 SHALL wrap the FIFO read and write pointers modulo DEPTH, with no lost or duplicated bytes.
REQ-024 SHALL count fifo_level only stored entries; the byte in the shift register is not counted.
REQ-025 SHALL update fifo_level on the edge after each push or pop.
REQ-026 SHALL assert busy = (state != IDLE) || (fifo_level != 0).

Reset
REQ-027 SHALL, while resetn = 0, asynchronously force:
- uart_tx = 1, wr_ready = 0, busy = 0, fifo_level = 0;
- state = IDLE, bit and clock counters = 0, FIFO pointers = 0.
REQ-028 SHALL assert wr_ready on the first clk edge after resetn rises.
REQ-029 SHALL, on reset mid-frame, drop the frame and FIFO contents, return uart_tx to 1 at once, and emit no partial data after release.

Verification
REQ-030 SHALL cover single byte: cfg_div=4, write 0xA5 into an idle empty FIFO.
- uart_tx low at E0+1 for 4 cycles.
- Then bits 1,0,1,0,0,1,0,1, 4 cycles each.
- Then stop high for 4 cycles; busy falls after the stop bit; frame is 40 cycles total.
REQ-031 SHALL cover back-to-back frames: cfg_div=4, write 0x55 then 0x0F on consecutive cycles -> two 40-cycle frames, contiguous, and a uart_vip at CLK_HZ 100000000 / BAUDRATE 25000000 decodes 0x55, 0x0F.
REQ-032 SHALL cover full FIFO: cfg_div=16, burst-write 10 bytes 0x00..0x09 with wr_valid held high.
- wr_ready drops when fifo_level=8, with byte 0 in the shifter.
- Byte 9 is accepted after the first pop.
- All 10 bytes arrive in order.
REQ-033 SHALL cover simultaneous push and pop: with fifo_level=3, push on the pop edge -> fifo_level stays 3 and output order is preserved.
REQ-034 SHALL cover minimum divider: cfg_div=0, write 0xFF -> each bit lasts 2 cycles and the frame is 20 cycles.
REQ-035 SHALL cover reset mid-frame: resetn low during data bit 3 of 0x3C with 2 bytes queued.
- uart_tx=1 and fifo_level=0 immediately.
- After release, the line stays high with no further frames.
